clusterv_banked_sram_ctrl: RTL and testbench

Parametrised Wishbone-target SRAM controller that serves the SoC main-memory window from `N_BANKS` byte-enable SRAM macros. It replaces the fixed four-bank, contiguous-decode arrangement in the SoC top with a self-contained block. The block adds:
- selectable contiguous or word-interleaved bank mapping;
- configurable macro read latency;
- out-of-range error response;
- clean abort when `t_cyc` drops.

It sits between the `TARGET_IDX_SRAM` target port of the core interconnect and the main SRAM macros.

---
 rtl/clusterv_sram_ctrl_pkg.sv | 38 +++
 rtl/clusterv_sram_bank_decode.sv | 57 +++++
 rtl/clusterv_banked_sram_ctrl.sv | 166 ++++++++++++++++
 tb/tb_clusterv_banked_sram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clusterv_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clusterv_sram_ctrl_pkg
//  Description : Shared FSM state encodings, bank-mapping constants and the
//                clog2 helper for the banked SRAM controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clusterv_sram_ctrl_pkg;

    // Controller states; 2-bit encoding leaves one unused code.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

    // Bank mapping selection values for the INTERLEAVE parameter.
    localparam int unsigned MAP_CONTIGUOUS  = 0;
    localparam int unsigned MAP_INTERLEAVED = 1;

    // Latency counter only ever holds READ_LATENCY-1, at most 2.
    localparam int unsigned LAT_CNT_W = 2;

    // Ceiling log2; clog2(1) = 0 so a single-bank build has no bank bits.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clusterv_sram_bank_decode.sv
`default_nettype none
// ============================================================================
//  Module      : clusterv_sram_bank_decode
//  Description : Combinational map from a Wishbone byte address to bank
//                index, in-bank row and an out-of-window flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module clusterv_sram_bank_decode
    import clusterv_sram_ctrl_pkg::*;
#(
    parameter int unsigned N_BANKS          = 4,
    parameter int unsigned BANK_ADR_WIDTH   = 10,
    parameter int unsigned WINDOW_ADR_WIDTH = 20,
    parameter int unsigned INTERLEAVE       = 0,
    localparam int unsigned BB              = clog2(N_BANKS),
    localparam int unsigned BIW             = (BB == 0) ? 1 : BB
) (
    input  logic [31:0]               adr_i,
    output logic [BIW-1:0]            bank_o,
    output logic [BANK_ADR_WIDTH-1:0] row_o,
    output logic                      out_of_range_o
);

    localparam int unsigned TW = BANK_ADR_WIDTH + BB;

    logic [TW-1:0] w_word;

    // Word index: byte offset bits are dropped.
    assign w_word = adr_i[2 +: TW];

    // Address bits outside the decoded word index are intentionally ignored.
    wire w_unused_adr = ^adr_i;

    generate
        if (BB == 0) begin : g_single_bank
            assign bank_o = '0;
            assign row_o  = w_word;
        end else if (INTERLEAVE == MAP_INTERLEAVED) begin : g_interleaved
            // Consecutive words rotate across banks.
            assign bank_o = w_word[BB-1:0];
            assign row_o  = w_word[TW-1:BB];
        end else begin : g_contiguous
            // Each bank owns one contiguous block of the window.
            assign bank_o = w_word[TW-1:BANK_ADR_WIDTH];
            assign row_o  = w_word[BANK_ADR_WIDTH-1:0];
        end

        if (WINDOW_ADR_WIDTH > 2 + TW) begin : g_range_check
            // Any window bit above the populated memory flags an error.
            assign out_of_range_o = |adr_i[WINDOW_ADR_WIDTH-1:2+TW];
        end else begin : g_no_range_check
            assign out_of_range_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/clusterv_banked_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clusterv_banked_sram_ctrl
//  Description : Wishbone target serving the main-memory window from
//                N_BANKS byte-enable SRAM macros, with contiguous or
//                interleaved mapping, configurable read latency, error
//                response for unpopulated addresses and cycle abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module clusterv_banked_sram_ctrl
    import clusterv_sram_ctrl_pkg::*;
#(
    parameter int unsigned N_BANKS          = 4,
    parameter int unsigned BANK_ADR_WIDTH   = 10,
    parameter int unsigned WINDOW_ADR_WIDTH = 20,
    parameter int unsigned INTERLEAVE       = 0,
    parameter int unsigned READ_LATENCY     = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               t_adr,
    input  logic [31:0]               t_dat_w,
    output logic [31:0]               t_dat_r,
    input  logic                      t_cyc,
    input  logic                      t_stb,
    input  logic                      t_we,
    input  logic [3:0]                t_sel,
    output logic                      t_ack,
    output logic                      t_err,
    input  logic [3:0]                t_tgc,
    input  logic                      t_tga,
    input  logic                      t_tgd_w,
    output logic                      t_tgd_r,
    output logic [BANK_ADR_WIDTH-1:0] sram_addr,
    output logic [31:0]               sram_write_data,
    input  logic [32*N_BANKS-1:0]     sram_read_data,
    output logic [N_BANKS-1:0]        sram_write_en,
    output logic [N_BANKS-1:0]        sram_read_en,
    output logic [4*N_BANKS-1:0]      sram_byte_en
);

    localparam int unsigned BB  = clog2(N_BANKS);
    localparam int unsigned BIW = (BB == 0) ? 1 : BB;

    state_e                   state_q;
    logic [LAT_CNT_W-1:0]     cnt_q;
    logic [BIW-1:0]           bank_q;
    logic                     ack_q;
    logic                     err_q;
    logic [31:0]              dat_q;

    logic [BIW-1:0]           w_bank;
    logic [BANK_ADR_WIDTH-1:0] w_row;
    logic                     w_oor;
    logic                     w_req;
    logic                     w_accept;
    logic [31:0]              w_rd_data;

    // Tag inputs carry no meaning for this target.
    wire w_unused_tags = ^{t_tgc, t_tga, t_tgd_w};

    clusterv_sram_bank_decode #(
        .N_BANKS          (N_BANKS),
        .BANK_ADR_WIDTH   (BANK_ADR_WIDTH),
        .WINDOW_ADR_WIDTH (WINDOW_ADR_WIDTH),
        .INTERLEAVE       (INTERLEAVE)
    ) u_decode (
        .adr_i          (t_adr),
        .bank_o         (w_bank),
        .row_o          (w_row),
        .out_of_range_o (w_oor)
    );

    assign w_req    = t_cyc & t_stb;
    // Only an idle controller outside reset may launch an SRAM access.
    assign w_accept = (state_q == ST_IDLE) & w_req & ~reset;

    // SRAM strobes fire only in the acceptance cycle of an in-range request.
    always_comb begin
        sram_addr       = w_row;
        sram_write_data = t_dat_w;
        sram_write_en   = '0;
        sram_read_en    = '0;
        sram_byte_en    = '0;
        if (w_accept && !w_oor) begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (w_bank == BIW'(b)) begin
                    if (t_we) begin
                        sram_write_en[b]      = 1'b1;
                        sram_byte_en[4*b +: 4] = t_sel;
                    end else begin
                        sram_read_en[b] = 1'b1;
                    end
                end
            end
        end
    end

    // Return-data mux driven by the bank latched at read acceptance.
    always_comb begin
        w_rd_data = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (bank_q == BIW'(b)) begin
                w_rd_data = sram_read_data[32*b +: 32];
            end
        end
    end

    // Request FSM, latency counter and registered Wishbone responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_oor) begin
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else if (t_we) begin
                            ack_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            bank_q  <= w_bank;
                            cnt_q   <= LAT_CNT_W'(READ_LATENCY - 1);
                            state_q <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // Abort wins over a capture landing in the same cycle.
                    if (!t_cyc) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        dat_q   <= w_rd_data;
                        ack_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign t_ack   = ack_q;
    assign t_err   = err_q;
    assign t_dat_r = dat_q;
    assign t_tgd_r = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_clusterv_banked_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clusterv_banked_sram_ctrl
//  Description : Directed bench; three controller builds (contiguous,
//                interleaved, 3-cycle latency) each with an SRAM macro model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clusterv_banked_sram_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    int          dsel;

    logic [2:0]        cycv;
    logic [2:0][31:0]  dat_r;
    logic [2:0]        ack;
    logic [2:0]        err;
    logic [2:0]        tgd_r;
    logic [2:0][9:0]   saddr;
    logic [2:0][31:0]  swd;
    logic [2:0][3:0]   swe;
    logic [2:0][3:0]   sre;
    logic [2:0][15:0]  sbe;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cycv = cyc ? (3'b001 << dsel) : 3'b000;

    // Build 0: defaults; build 1: interleaved; build 2: read latency 3.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 2) ? 3 : 1;
        logic [31:0]  mem [4][1024];
        logic [31:0]  s1 [4];
        logic [31:0]  s2 [4];
        logic [31:0]  s3 [4];
        logic [127:0] rd;

        always @(posedge clk) begin
            for (int b = 0; b < 4; b++) begin
                if (swe[k][b]) begin
                    for (int y = 0; y < 4; y++) begin
                        if (sbe[k][4*b+y]) mem[b][saddr[k]][8*y +: 8] <= swd[k][8*y +: 8];
                    end
                end
                s1[b] <= mem[b][saddr[k]];
                s2[b] <= s1[b];
                s3[b] <= s2[b];
            end
        end

        always_comb begin
            rd = '0;
            for (int b = 0; b < 4; b++) rd[32*b +: 32] = (LAT == 3) ? s3[b] : s1[b];
        end

        clusterv_banked_sram_ctrl #(
            .N_BANKS          (4),
            .BANK_ADR_WIDTH   (10),
            .WINDOW_ADR_WIDTH (20),
            .INTERLEAVE       ((k == 1) ? 1 : 0),
            .READ_LATENCY     (LAT)
        ) u_dut (
            .clock           (clk),
            .reset           (rst),
            .t_adr           (adr),
            .t_dat_w         (dat_w),
            .t_dat_r         (dat_r[k]),
            .t_cyc           (cycv[k]),
            .t_stb           (stb),
            .t_we            (we),
            .t_sel           (sel),
            .t_ack           (ack[k]),
            .t_err           (err[k]),
            .t_tgc           (4'h0),
            .t_tga           (1'b0),
            .t_tgd_w         (1'b0),
            .t_tgd_r         (tgd_r[k]),
            .sram_addr       (saddr[k]),
            .sram_write_data (swd[k]),
            .sram_read_data  (rd),
            .sram_write_en   (swe[k]),
            .sram_read_en    (sre[k]),
            .sram_byte_en    (sbe[k])
        );
    end

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] a;
        logic [31:0] dw;
        logic [3:0]  s;
        int          lat;
        logic        e;
        logic [31:0] rd;
        logic [3:0]  xwe;
        logic [3:0]  xre;
        logic [15:0] xbe;
        logic [9:0]  row;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    function automatic vec_t mk(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] dw, input logic [3:0] s, input int lat,
                                input logic e, input logic [31:0] rdv, input logic [3:0] xwe,
                                input logic [3:0] xre, input logic [15:0] xbe, input logic [9:0] row);
        vec_t v;
        v.d = d; v.w = w; v.a = a; v.dw = dw; v.s = s; v.lat = lat; v.e = e;
        v.rd = rdv; v.xwe = xwe; v.xre = xre; v.xbe = xbe; v.row = row;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One Wishbone access; reports response cycle, cycle-0 strobes, strobes
    // seen after cycle 0, and whether the response lasted longer than a cycle.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] dw, input logic [3:0] s,
                          output int lat, output logic got_err,
                          output logic [3:0] we0, output logic [3:0] re0,
                          output logic [15:0] be0, output logic [9:0] row0,
                          output int late, output logic long_resp);
        @(posedge clk); #1;
        dsel = d; adr = a; dat_w = dw; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        #1;
        we0 = swe[d]; re0 = sre[d]; be0 = sbe[d]; row0 = saddr[d];
        lat = -1; got_err = 1'b0; late = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (swe[d] != 0 || sre[d] != 0 || sbe[d] != 0) late++;
            if (ack[d] || err[d]) begin
                lat = n;
                got_err = err[d];
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        long_resp = ack[d] | err[d];
    endtask

    int          lat;
    logic        gerr;
    logic [3:0]  we0;
    logic [3:0]  re0;
    logic [15:0] be0;
    logic [9:0]  row0;
    int          late;
    logic        lresp;
    logic [31:0] prev;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; adr = '0; dat_w = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; dsel = 0;

        // d  w  addr          wdata         sel lat e  rdata         we      re      be        row
        vt[0]  = mk(0, 1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0,         4'b0010, 4'b0000, 16'h00F0, 10'h001);
        vt[1]  = mk(0, 0, 32'h0000_1004, 32'h0,         4'hF, 2, 0, 32'hDEAD_BEEF, 4'b0000, 4'b0010, 16'h0000, 10'h001);
        vt[2]  = mk(0, 1, 32'h0000_0000, 32'h1111_1111, 4'hF, 1, 0, 32'h0,         4'b0001, 4'b0000, 16'h000F, 10'h000);
        vt[3]  = mk(0, 1, 32'h0000_2FFC, 32'h2222_2222, 4'hF, 1, 0, 32'h0,         4'b0100, 4'b0000, 16'h0F00, 10'h3FF);
        vt[4]  = mk(0, 1, 32'h0000_3008, 32'h3333_3333, 4'hF, 1, 0, 32'h0,         4'b1000, 4'b0000, 16'hF000, 10'h002);
        vt[5]  = mk(0, 0, 32'h0000_0000, 32'h0,         4'hF, 2, 0, 32'h1111_1111, 4'b0000, 4'b0001, 16'h0000, 10'h000);
        vt[6]  = mk(0, 0, 32'h0000_2FFC, 32'h0,         4'hF, 2, 0, 32'h2222_2222, 4'b0000, 4'b0100, 16'h0000, 10'h3FF);
        vt[7]  = mk(0, 0, 32'h0000_3008, 32'h0,         4'hF, 2, 0, 32'h3333_3333, 4'b0000, 4'b1000, 16'h0000, 10'h002);
        vt[8]  = mk(0, 0, 32'h0000_4000, 32'h0,         4'hF, 1, 1, 32'h0,         4'b0000, 4'b0000, 16'h0000, 10'h000);
        vt[9]  = mk(0, 1, 32'h0008_0000, 32'h9999_9999, 4'hF, 1, 1, 32'h0,         4'b0000, 4'b0000, 16'h0000, 10'h000);
        vt[10] = mk(0, 0, 32'h0010_0000, 32'h0,         4'hF, 2, 0, 32'h1111_1111, 4'b0000, 4'b0001, 16'h0000, 10'h000);
        vt[11] = mk(0, 1, 32'h0000_0000, 32'h0,         4'h0, 1, 0, 32'h0,         4'b0001, 4'b0000, 16'h0000, 10'h000);
        vt[12] = mk(0, 0, 32'h0000_0000, 32'h0,         4'hF, 2, 0, 32'h1111_1111, 4'b0000, 4'b0001, 16'h0000, 10'h000);
        vt[13] = mk(1, 1, 32'h0000_0000, 32'hA0A0_A0A0, 4'hF, 1, 0, 32'h0,         4'b0001, 4'b0000, 16'h000F, 10'h000);
        vt[14] = mk(1, 1, 32'h0000_0004, 32'hA1A1_A1A1, 4'hF, 1, 0, 32'h0,         4'b0010, 4'b0000, 16'h00F0, 10'h000);
        vt[15] = mk(1, 1, 32'h0000_0008, 32'hA2A2_A2A2, 4'hF, 1, 0, 32'h0,         4'b0100, 4'b0000, 16'h0F00, 10'h000);
        vt[16] = mk(1, 1, 32'h0000_000C, 32'hA3A3_A3A3, 4'hF, 1, 0, 32'h0,         4'b1000, 4'b0000, 16'hF000, 10'h000);
        vt[17] = mk(1, 1, 32'h0000_0010, 32'hB0B0_B0B0, 4'hF, 1, 0, 32'h0,         4'b0001, 4'b0000, 16'h000F, 10'h001);
        vt[18] = mk(1, 0, 32'h0000_0000, 32'h0,         4'hF, 2, 0, 32'hA0A0_A0A0, 4'b0000, 4'b0001, 16'h0000, 10'h000);
        vt[19] = mk(1, 0, 32'h0000_0004, 32'h0,         4'hF, 2, 0, 32'hA1A1_A1A1, 4'b0000, 4'b0010, 16'h0000, 10'h000);
        vt[20] = mk(1, 0, 32'h0000_0008, 32'h0,         4'hF, 2, 0, 32'hA2A2_A2A2, 4'b0000, 4'b0100, 16'h0000, 10'h000);
        vt[21] = mk(1, 0, 32'h0000_000C, 32'h0,         4'hF, 2, 0, 32'hA3A3_A3A3, 4'b0000, 4'b1000, 16'h0000, 10'h000);
        vt[22] = mk(1, 0, 32'h0000_0010, 32'h0,         4'hF, 2, 0, 32'hB0B0_B0B0, 4'b0000, 4'b0001, 16'h0000, 10'h001);
        vt[23] = mk(1, 0, 32'h0000_4000, 32'h0,         4'hF, 1, 1, 32'h0,         4'b0000, 4'b0000, 16'h0000, 10'h000);
        vt[24] = mk(2, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1, 0, 32'h0,         4'b0001, 4'b0000, 16'h000F, 10'h000);
        vt[25] = mk(2, 1, 32'h0000_0000, 32'h0000_AB00, 4'h2, 1, 0, 32'h0,         4'b0001, 4'b0000, 16'h0002, 10'h000);
        vt[26] = mk(2, 0, 32'h0000_0000, 32'h0,         4'hF, 4, 0, 32'hFFFF_ABFF, 4'b0000, 4'b0001, 16'h0000, 10'h000);
        vt[27] = mk(2, 1, 32'h0000_1004, 32'h1234_5678, 4'hF, 1, 0, 32'h0,         4'b0010, 4'b0000, 16'h00F0, 10'h001);
        vt[28] = mk(2, 0, 32'h0000_1004, 32'h0,         4'hF, 4, 0, 32'h1234_5678, 4'b0000, 4'b0010, 16'h0000, 10'h001);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ack%0d", k), {31'b0, ack[k]}, 32'h0);
            check($sformatf("reset_err%0d", k), {31'b0, err[k]}, 32'h0);
            check($sformatf("reset_datr%0d", k), dat_r[k], 32'h0);
        end
        check("tgd_r", {29'b0, tgd_r}, 32'h0);

        // Table-driven accesses.
        for (int i = 0; i < NV; i++) begin
            prev = dat_r[vt[i].d];
            access(vt[i].d, vt[i].w, vt[i].a, vt[i].dw, vt[i].s,
                   lat, gerr, we0, re0, be0, row0, late, lresp);
            check($sformatf("v%0d_latency", i), lat, vt[i].lat);
            check($sformatf("v%0d_err", i), {31'b0, gerr}, {31'b0, vt[i].e});
            check($sformatf("v%0d_write_en", i), {28'b0, we0}, {28'b0, vt[i].xwe});
            check($sformatf("v%0d_read_en", i), {28'b0, re0}, {28'b0, vt[i].xre});
            check($sformatf("v%0d_late_strobes", i), late, 0);
            check($sformatf("v%0d_resp_pulse", i), {31'b0, lresp}, 32'h0);
            if (vt[i].w) check($sformatf("v%0d_byte_en", i), {16'b0, be0}, {16'b0, vt[i].xbe});
            if ((vt[i].xwe | vt[i].xre) != 0) check($sformatf("v%0d_row", i), {22'b0, row0}, {22'b0, vt[i].row});
            if (!vt[i].w && !vt[i].e) check($sformatf("v%0d_rdata", i), dat_r[vt[i].d], vt[i].rd);
            else check($sformatf("v%0d_datr_hold", i), dat_r[vt[i].d], prev);
        end

        // Abort: drop t_cyc while the latency-3 build waits on a read.
        @(posedge clk); #1;
        dsel = 2; adr = 32'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        #1;
        check("abort_read_en", {28'b0, sre[2]}, 32'h1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        #1;
        check("abort_no_ack_c1", {31'b0, ack[2]}, 32'h0);
        access(2, 1'b1, 32'h0000_0008, 32'h5555_5555, 4'hF, lat, gerr, we0, re0, be0, row0, late, lresp);
        check("abort_then_write_en", {28'b0, we0}, 32'h1);
        check("abort_then_write_row", {22'b0, row0}, 32'h2);
        check("abort_then_write_lat", lat, 1);
        check("abort_stray_ack", {31'b0, lresp}, 32'h0);
        check("abort_datr_hold", dat_r[2], 32'h1234_5678);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check($sformatf("abort_quiet%0d", n), {30'b0, ack[2], err[2]}, 32'h0);
        end

        // Reset in the middle of a latency-3 read, request still held.
        @(posedge clk); #1;
        dsel = 2; adr = 32'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ack", {31'b0, ack[2]}, 32'h0);
        check("rst_datr", dat_r[2], 32'h0);
        check("rst_datr_dut0", dat_r[0], 32'h0);
        check("rst_strobes", {24'b0, swe[2], sre[2]}, 32'h0);
        check("rst_byte_en", {16'b0, sbe[2]}, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("rst_after_ack", {30'b0, ack[2], err[2]}, 32'h0);
        access(2, 1'b0, 32'h0, 32'h0, 4'hF, lat, gerr, we0, re0, be0, row0, late, lresp);
        check("rst_recover_lat", lat, 4);
        check("rst_recover_data", dat_r[2], 32'hFFFF_ABFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
